// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the alu and its sequencer.
package alu_pkg;

    localparam logic [2:0] OP_ZERO  = 3'b000;
    localparam logic [2:0] OP_ONES  = 3'b001;
    localparam logic [2:0] OP_PASSA = 3'b010;
    localparam logic [2:0] OP_PASSB = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_OR    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_prog_rf.sv
// Program store: DEPTH x 3 control codes, one gated synchronous write port and one async read port.
// Read is combinational; writes land on the next edge only while allow_i is high.
module alu_prog_rf
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          allow_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [2:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [2:0]    rdata_o
);

    logic [2:0] slots [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= OP_ZERO;
            end
        end else if (we_i && allow_i) begin
            slots[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = slots[raddr_i];

endmodule

// File: rtl/alu_seq.sv
// Steps a stored op program through the external alu, feeding {B,C} back as {A,B}.
// Latency len+1 cycles from en_i to done_o; en_i while busy is dropped and flagged in overrun_o.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [2*WIDTH-1:0] seed_i,
    input  logic [AW:0]        len_i,
    input  logic               prog_we_i,
    input  logic [AW-1:0]      prog_addr_i,
    input  logic [2:0]         prog_ctl_i,
    output logic               alu_en_o,
    output logic [2:0]         alu_ctl_o,
    output logic [2*WIDTH-1:0] alu_AB_o,
    input  logic [2*WIDTH-1:0] alu_BC_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               overrun_o
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] ab_q;
    logic [2*WIDTH-1:0] result_q;
    logic [AW:0]        n_q;
    logic [AW-1:0]      step_q;
    logic               overrun_q;
    logic [2:0]         prog_ctl;
    logic [AW:0]        len_clamped;
    logic               last_step;

    alu_prog_rf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_rf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (prog_we_i),
        .allow_i (state_q == ST_IDLE),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_ctl_i),
        .raddr_i (step_q),
        .rdata_o (prog_ctl)
    );

    assign len_clamped = (len_i > DEPTH_L) ? DEPTH_L : len_i;
    assign last_step   = ({1'b0, step_q} == (n_q - ONE_L));

    always_comb begin
        state_d   = state_q;
        alu_en_o  = 1'b0;
        alu_ctl_o = OP_ZERO;
        done_o    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                alu_en_o  = 1'b1;
                alu_ctl_o = prog_ctl;
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            ab_q      <= '0;
            result_q  <= '0;
            n_q       <= '0;
            step_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        ab_q   <= seed_i;
                        n_q    <= len_clamped;
                        step_q <= '0;
                    end
                end
                ST_RUN: begin
                    ab_q   <= alu_BC_i;
                    step_q <= step_q + 1'b1;
                end
                ST_DONE: begin
                    result_q <= ab_q;
                end
                default: ;
            endcase
            // Overrun is sticky: only reset clears it.
            if (en_i && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign alu_AB_o  = ab_q;
    assign result_o  = result_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural alu closing the {B,C} -> {A,B} loop.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [15:0] seed_i;
    logic [3:0]  len_i;
    logic        prog_we_i;
    logic [2:0]  prog_addr_i;
    logic [2:0]  prog_ctl_i;
    logic        alu_en_o;
    logic [2:0]  alu_ctl_o;
    logic [15:0] alu_AB_o;
    logic [15:0] alu_BC_i;
    logic [15:0] result_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    alu_seq #(.WIDTH(8), .DEPTH(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .seed_i      (seed_i),
        .len_i       (len_i),
        .prog_we_i   (prog_we_i),
        .prog_addr_i (prog_addr_i),
        .prog_ctl_i  (prog_ctl_i),
        .alu_en_o    (alu_en_o),
        .alu_ctl_o   (alu_ctl_o),
        .alu_AB_o    (alu_AB_o),
        .alu_BC_i    (alu_BC_i),
        .result_o    (result_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    // Behavioural alu: {A,B} -> {B, op(A,B)} modulo 256.
    logic [7:0] alu_a, alu_b, alu_c;
    always_comb begin
        alu_a = alu_AB_o[15:8];
        alu_b = alu_AB_o[7:0];
        case (alu_ctl_o)
            OP_ZERO:  alu_c = 8'h00;
            OP_ONES:  alu_c = 8'hFF;
            OP_PASSA: alu_c = alu_a;
            OP_PASSB: alu_c = alu_b;
            OP_ADD:   alu_c = alu_a + alu_b;
            OP_SUB:   alu_c = alu_a - alu_b;
            OP_AND:   alu_c = alu_a & alu_b;
            default:  alu_c = alu_a | alu_b;
        endcase
        alu_BC_i = {alu_b, alu_c};
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_slot(input logic [2:0] addr, input logic [2:0] op);
        prog_we_i   = 1'b1;
        prog_addr_i = addr;
        prog_ctl_i  = op;
        step();
        prog_we_i   = 1'b0;
    endtask

    // Pulse en_i across one edge (edge k); returns in cycle k+1.
    task automatic start_run(input logic [15:0] seed, input logic [3:0] len);
        seed_i = seed;
        len_i  = len;
        en_i   = 1'b1;
        step();
        en_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
        checks++;
        if ({busy_o, done_o, alu_en_o, overrun_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {busy_o, done_o, alu_en_o, overrun_o});
        end
        checks++;
        if (result_o !== 16'h0000 || alu_AB_o !== 16'h0000 || alu_ctl_o !== OP_ZERO) begin
            errors++;
            $display("FAIL reset_data result=%h ab=%h ctl=%b want 0000 0000 000", result_o, alu_AB_o, alu_ctl_o);
        end
    endtask

    task automatic test_fibonacci();
        logic [15:0] exp_ab [4] = '{16'h0305, 16'h0508, 16'h080D, 16'h0D15};
        for (int i = 0; i < 8; i++) write_slot(3'(i), OP_ADD);
        start_run(16'h0305, 4'd4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (alu_AB_o !== exp_ab[i] || alu_en_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0 || alu_ctl_o !== OP_ADD) begin
                errors++;
                $display("FAIL fib_step%0d ab=%h en=%b busy=%b done=%b ctl=%b want ab=%h en=1 busy=1 done=0 ctl=100",
                         i, alu_AB_o, alu_en_o, busy_o, done_o, alu_ctl_o, exp_ab[i]);
            end
            step();
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || alu_en_o !== 1'b0) begin
            errors++;
            $display("FAIL fib_done done=%b busy=%b en=%b want 1 1 0", done_o, busy_o, alu_en_o);
        end
        step();
        checks++;
        if (result_o !== 16'h1522 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL fib_result result=%h done=%b busy=%b want 1522 0 0", result_o, done_o, busy_o);
        end
    endtask

    // slot1 is rewritten to SUB in the same IDLE cycle as en_i; the run must see SUB.
    task automatic test_wrap_mixed();
        write_slot(3'd0, OP_ADD);
        prog_we_i   = 1'b1;
        prog_addr_i = 3'd1;
        prog_ctl_i  = OP_SUB;
        start_run(16'hC864, 4'd2);
        prog_we_i   = 1'b0;
        checks++;
        if (alu_AB_o !== 16'hC864 || alu_BC_i !== 16'h642C) begin
            errors++;
            $display("FAIL wrap_step0 ab=%h bc=%h want C864 642C", alu_AB_o, alu_BC_i);
        end
        step();
        checks++;
        if (alu_AB_o !== 16'h642C || alu_BC_i !== 16'h2C38 || alu_ctl_o !== OP_SUB) begin
            errors++;
            $display("FAIL wrap_step1 ab=%h bc=%h ctl=%b want 642C 2C38 101", alu_AB_o, alu_BC_i, alu_ctl_o);
        end
        step();
        step();
        checks++;
        if (result_o !== 16'h2C38) begin
            errors++;
            $display("FAIL wrap_result got %h want 2C38", result_o);
        end
    endtask

    task automatic test_len_zero();
        start_run(16'hABCD, 4'd0);
        checks++;
        if (done_o !== 1'b1 || alu_en_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL len0_done done=%b en=%b busy=%b want 1 0 1", done_o, alu_en_o, busy_o);
        end
        step();
        checks++;
        if (result_o !== 16'hABCD || alu_en_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL len0_result result=%h en=%b busy=%b want ABCD 0 0", result_o, alu_en_o, busy_o);
        end
    endtask

    task automatic test_overrun_lockout();
        write_slot(3'd1, OP_ADD);
        start_run(16'h0101, 4'd8);                 // cycle k+1
        step();                                    // cycle k+2
        prog_we_i   = 1'b1;
        prog_addr_i = 3'd2;
        prog_ctl_i  = OP_OR;
        step();                                    // cycle k+3
        prog_we_i   = 1'b0;
        en_i        = 1'b1;
        seed_i      = 16'hFFFF;
        len_i       = 4'd1;
        checks++;
        if (overrun_o !== 1'b0 || alu_AB_o !== 16'h0203) begin
            errors++;
            $display("FAIL ovr_before overrun=%b ab=%h want 0 0203", overrun_o, alu_AB_o);
        end
        step();                                    // cycle k+4
        en_i = 1'b0;
        checks++;
        if (overrun_o !== 1'b1 || alu_AB_o !== 16'h0305) begin
            errors++;
            $display("FAIL ovr_after overrun=%b ab=%h want 1 0305", overrun_o, alu_AB_o);
        end
        for (int i = 0; i < 5; i++) step();        // cycle k+9
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_done_time done=%b want 1", done_o);
        end
        step();
        checks++;
        if (result_o !== 16'h2237 || overrun_o !== 1'b1) begin
            errors++;
            $display("FAIL ovr_result result=%h overrun=%b want 2237 1", result_o, overrun_o);
        end
        start_run(16'h0101, 4'd3);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (result_o !== 16'h0305) begin
            errors++;
            $display("FAIL ovr_slot2_kept result=%h want 0305", result_o);
        end
    endtask

    task automatic test_clamp();
        int run_cycles;
        for (int i = 0; i < 8; i++) write_slot(3'(i), OP_PASSB);
        start_run(16'h1122, 4'd15);
        run_cycles = 0;
        for (int i = 0; i < 12 && done_o !== 1'b1; i++) begin
            if (alu_en_o === 1'b1) run_cycles++;
            step();
        end
        checks++;
        if (run_cycles != 8 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL clamp_cycles run=%0d done=%b want 8 1", run_cycles, done_o);
        end
        step();
        checks++;
        if (result_o !== 16'h2222) begin
            errors++;
            $display("FAIL clamp_result got %h want 2222", result_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        int bad_ctl;
        start_run(16'h0102, 4'd6);                 // cycle k+1
        step();                                    // cycle k+2
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, alu_en_o, overrun_o, done_o} !== 4'b0000 || result_o !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid flags=%b result=%h want 0000 0000", {busy_o, alu_en_o, overrun_o, done_o}, result_o);
        end
        step();
        rst_i = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o === 1'b1 || busy_o === 1'b1) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL rst_no_done activity=%0d want 0", done_seen);
        end
        start_run(16'h1234, 4'd8);
        bad_ctl = 0;
        for (int i = 0; i < 8; i++) begin
            if (alu_ctl_o !== OP_ZERO || alu_en_o !== 1'b1) bad_ctl++;
            if (i == 1) begin
                checks++;
                if (alu_AB_o !== 16'h3400) begin
                    errors++;
                    $display("FAIL rst_zero_step1 ab=%h want 3400", alu_AB_o);
                end
            end
            step();
        end
        checks++;
        if (bad_ctl != 0) begin
            errors++;
            $display("FAIL rst_slots_zero bad=%0d want 0", bad_ctl);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        en_i        = 1'b0;
        seed_i      = '0;
        len_i       = '0;
        prog_we_i   = 1'b0;
        prog_addr_i = '0;
        prog_ctl_i  = '0;
        test_reset();
        test_fibonacci();
        test_wrap_mixed();
        test_len_zero();
        test_overrun_lockout();
        test_clamp();
        test_reset_mid_run();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencer that drives the combinational alu stage (`WIDTH` default 8) and consumes its output.
- It holds a small program of ALU control codes. On a 1-cycle enable strobe (VSYNC in the VGA/Pong build) it seeds an {A,B} operand pair.
- It then steps the program, feeding each {B,C} result back as the next {A,B} input.
- At the end it presents the final {B,C} pair with a done pulse.
- It sits between frame-rate control logic (upstream) and the alu (downstream and feedback).

Parameters:
- WIDTH, 8, operand width; the ALU bus is 2*WIDTH.
- DEPTH, 8, number of program slots; power of two, ≥2.
- AW, $clog2(DEPTH), width of the program address field.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  run strobe, one cycle wide (VSYNC).
- seed_i  in  2*WIDTH  initial {A,B}, sampled on the accepted en_i.
- len_i  in  AW+1  number of ops to run, 0..DEPTH, sampled on the accepted en_i.
- prog_we_i  in  1  program write enable.
- prog_addr_i  in  AW  program slot address.
- prog_ctl_i  in  3  control code written to the slot.
- alu_en_o  out  1  drives alu en_i; high only in RUN.
- alu_ctl_o  out  3  drives alu ctl_i.
- alu_AB_o  out  2*WIDTH  drives alu AB_i.
- alu_BC_i  in  2*WIDTH  from alu BC_o; combinational, same cycle.
- result_o  out  2*WIDTH  last completed {B,C}; held until the next run completes.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse in DONE.
- overrun_o  out  1  sticky; set when en_i arrives while busy.

Behaviour:
- Reset (async, rst_i=1): all outputs, registers and program slots are cleared.
  - Slot value 3'b000 is op ZERO.
  - State returns to IDLE immediately.
  - A run in progress is abandoned. result_o is not updated and done_o is not pulsed.
- States: IDLE, RUN, DONE.
- IDLE:
  - alu_en_o=0, alu_ctl_o=0, alu_AB_o=ab_q.
  - On en_i: ab_q<=seed_i, n_q<=len_i, step_q<=0.
  - If len_i==0, go to DONE; otherwise go to RUN.
- RUN:
  - Outputs: alu_en_o=1, alu_ctl_o=prog[step_q], alu_AB_o=ab_q.
  - Each cycle: ab_q<=alu_BC_i and step_q<=step_q+1.
  - When step_q==n_q-1, go to DONE.
  - RUN lasts exactly n_q cycles.
- DONE:
  - result_o<=ab_q, done_o=1 for exactly this cycle.
  - Go to IDLE.
  - For len 0, result_o equals seed_i.
- Latency:
  - en_i sampled at edge k; RUN occupies cycles k+1..k+n; DONE is at cycle k+n+1.
  - result_o is valid from edge k+n+2, and equally for n=0 (DONE at k+1, result valid from k+2).
  - The next en_i is accepted in IDLE, i.e. no earlier than cycle k+n+2.
- en_i while busy (RUN or DONE): ignored and overrun_o<=1.
  - overrun_o is cleared only by reset.
- Program writes:
  - Accepted in IDLE only. Writes in RUN or DONE are dropped silently, so a program is stable during a run.
  - A write and en_i in the same IDLE cycle: the write commits, and the run reads the new value.
- len_i>DEPTH: clamp n_q to DEPTH.
- Arithmetic lives in the alu, modulo 2^WIDTH. This block never alters data; it only routes and registers it.
- Invariant: step_q < DEPTH whenever state is RUN.
- alu_BC_i is sampled only in RUN; its value in IDLE or DONE is don't-care.

Decomposition:
- Package alu_pkg:
  - Opcode constants: OP_ZERO=000, OP_ONES=001, OP_PASSA=010, OP_PASSB=011, OP_ADD=100, OP_SUB=101, OP_AND=110, OP_OR=111.
  - State encoding: IDLE/RUN/DONE.
- One sub-module, alu_prog_rf:
  - DEPTH x 3 register file.
  - One synchronous write port, gated by an allow input tied to state==IDLE.
  - One asynchronous read port (address = step_q).
  - Async reset to OP_ZERO.
- The alu is instantiated by the parent, not inside alu_seq.

Test Plan:
- Fibonacci:
  - Stimulus: all 8 slots = OP_ADD, seed 0x0305, len 4, en_i pulse.
  - Required: alu_AB_o sequence 0x0305, 0x0508, 0x080D, 0x0D15; done_o at cycle k+5; result_o=0x1522; busy_o high cycles k+1..k+5.
- Wrap and mixed ops:
  - Stimulus: slot0=OP_ADD, slot1=OP_SUB, seed 0xC864, len 2.
  - Required: step0 gives {0x64,0x2C}; step1 gives {0x2C,0x38}; result_o=0x2C38.
- len 0:
  - Stimulus: seed 0xABCD, len 0.
  - Required: alu_en_o never high; done_o at k+1; result_o=0xABCD.
- Overrun and write lockout:
  - Stimulus: start len 8; pulse en_i at k+3; write slot2=OP_OR at k+2.
  - Required: overrun_o=1 from k+4; run unaffected; slot2 unchanged (verify with a later run).
- Reset mid-run:
  - Stimulus: assert rst_i asynchronously at k+2 of a len-6 run.
  - Required: immediately busy_o=0, alu_en_o=0, result_o=0, overrun_o=0, all slots OP_ZERO; no done_o pulse.
- Clamp:
  - Stimulus: len_i=15 (AW+1=4 bits), DEPTH 8, all slots OP_PASSB, seed 0x1122.
  - Required: exactly 8 RUN cycles; result_o=0x2222.
